// File: rtl/aes_mixcol_seq_wddl.sv
// aes_mixcol_seq_wddl
//   Time-shares one external WDDL MixColumns block across the four columns of
//   a 128-bit dual-rail AES state. Each column evaluation is preceded by
//   PRE_CYCLES cycles of all-zero (precharge) drive, the four result columns
//   are collected and the mixed state is returned over valid/ready. A bypass
//   path serves the final round, and a sticky checker flags any bit whose two
//   rails are equal on the accepted input or on the MixColumns result.
//
// Ports
//   clk                      clock, all state updates on the rising edge
//   rst                      synchronous reset, active low
//   in_valid / in_ready      input handshake; in_ready is high only when idle
//   bypass                   sampled with the input; 1 = result equals input
//   state_in_p / state_in_n  dual-rail input state, [127:120] = sa00,
//                            column c at bits [127-32c -: 32]
//   out_valid / out_ready    output handshake; result held until accepted
//   state_out_p / state_out_n dual-rail result, zero outside DONE
//   mc_col_p / mc_col_n      registered column to MixColumns, zero unless EVAL
//   mc_res_p / mc_res_n      MixColumns result (combinational in one cycle)
//   err                      sticky rail-violation flag, cleared by reset only
module aes_mixcol_seq_wddl #(
  parameter int PRE_CYCLES = 1,  // legal range 1..4
  parameter bit CHECK_EN   = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         bypass,
  input  logic [127:0] state_in_p,
  input  logic [127:0] state_in_n,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out_p,
  output logic [127:0] state_out_n,
  output logic [31:0]  mc_col_p,
  output logic [31:0]  mc_col_n,
  input  logic [31:0]  mc_res_p,
  input  logic [31:0]  mc_res_n,
  output logic         err
);

  typedef enum logic [1:0] {IDLE, PRE, EVAL, DONE} state_t;

  localparam logic [1:0] PRE_LAST = 2'(PRE_CYCLES - 1);

  state_t       state_q, state_d;
  logic [1:0]   col_q, col_d;
  logic [1:0]   pcnt_q, pcnt_d;
  logic [127:0] lat_p_q, lat_p_d, lat_n_q, lat_n_d;
  logic [127:0] res_p_q, res_p_d, res_n_q, res_n_d;
  logic [31:0]  mc_p_q, mc_p_d, mc_n_q, mc_n_d;
  logic         err_q, err_d;

  function automatic logic [31:0] get_col(input logic [127:0] s, input logic [1:0] c);
    case (c)
      2'd0:    return s[127:96];
      2'd1:    return s[95:64];
      2'd2:    return s[63:32];
      default: return s[31:0];
    endcase
  endfunction

  function automatic logic [127:0] put_col(input logic [127:0] s, input logic [1:0] c,
                                           input logic [31:0] v);
    logic [127:0] r;
    r = s;
    case (c)
      2'd0:    r[127:96] = v;
      2'd1:    r[95:64]  = v;
      2'd2:    r[63:32]  = v;
      default: r[31:0]   = v;
    endcase
    return r;
  endfunction

  always_comb begin
    // NOTE: every variable gets its hold/default value first so no path
    // through the case below can leave one unassigned and infer a latch.
    state_d = state_q;
    col_d   = col_q;
    pcnt_d  = pcnt_q;
    lat_p_d = lat_p_q;
    lat_n_d = lat_n_q;
    res_p_d = res_p_q;
    res_n_d = res_n_q;
    err_d   = err_q;
    mc_p_d  = '0;
    mc_n_d  = '0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          lat_p_d = state_in_p;
          lat_n_d = state_in_n;
          // A bit with equal rails is either a precharge leak or a fault.
          if (CHECK_EN && (|(~(state_in_p ^ state_in_n)))) err_d = 1'b1;
          if (bypass) begin
            res_p_d = state_in_p;
            res_n_d = state_in_n;
            state_d = DONE;
          end else begin
            col_d   = 2'd0;
            pcnt_d  = 2'd0;
            state_d = PRE;
          end
        end
      end
      PRE: begin
        pcnt_d = pcnt_q + 2'd1;
        if (pcnt_q == PRE_LAST) state_d = EVAL;
      end
      EVAL: begin
        // MixColumns is combinational, so its result is captured on the
        // same edge that ends the evaluation cycle.
        res_p_d = put_col(res_p_q, col_q, mc_res_p);
        res_n_d = put_col(res_n_q, col_q, mc_res_n);
        if (CHECK_EN && (|(~(mc_res_p ^ mc_res_n)))) err_d = 1'b1;
        if (col_q == 2'd3) begin
          state_d = DONE;
        end else begin
          col_d   = col_q + 2'd1;
          pcnt_d  = 2'd0;
          state_d = PRE;
        end
      end
      default: begin  // DONE
        if (out_ready) state_d = IDLE;
      end
    endcase

    // mc_col is registered: load the column one edge ahead so it is on the
    // wires for exactly the EVAL cycle and zero (precharge) otherwise.
    if (state_d == EVAL) begin
      mc_p_d = get_col(lat_p_d, col_d);
      mc_n_d = get_col(lat_n_d, col_d);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the values present before the edge.
    if (!rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      pcnt_q  <= '0;
      res_p_q <= '0;
      res_n_q <= '0;
      mc_p_q  <= '0;
      mc_n_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      pcnt_q  <= pcnt_d;
      res_p_q <= res_p_d;
      res_n_q <= res_n_d;
      mc_p_q  <= mc_p_d;
      mc_n_q  <= mc_n_d;
      err_q   <= err_d;
    end
  end

  // NOTE: the input latch is deliberately not reset; it is always written on
  // accept before being read, and no output exposes it outside EVAL.
  always_ff @(posedge clk) begin
    lat_p_q <= lat_p_d;
    lat_n_q <= lat_n_d;
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign state_out_p = out_valid ? res_p_q : '0;
  assign state_out_n = out_valid ? res_n_q : '0;
  assign mc_col_p    = mc_p_q;
  assign mc_col_n    = mc_n_q;
  assign err         = CHECK_EN ? err_q : 1'b0;

endmodule
